mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch port and the data port of the memory-access stage.
- Each requester sees a req/ack handshake. The arbiter registers the granted request, drives the bus until the memory acknowledges, then returns read data and the ack to the owner.
- Includes a starvation guard for fetch and a per-transaction timeout that returns a bus error.

Parameters:
- XLEN, 32, address/data width.
- MAX_D_STREAK, 4, max consecutive data grants while fetch is waiting.
- TIMEOUT_CYCLES, 255, bus cycles without i_mem_ack before error; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request; held until o_if_ack
- i_if_addr  in  XLEN  fetch address
- o_if_ack  out  1  fetch done pulse
- o_if_err  out  1  fetch timed out; valid with o_if_ack
- o_if_rdata  out  XLEN  fetch data; valid with o_if_ack
- i_d_req  in  1  data request; held until o_d_ack
- i_d_we  in  1  1=store, 0=load
- i_d_addr  in  XLEN  data address
- i_d_wdata  in  XLEN  store data
- i_d_be  in  4  byte enables
- o_d_ack  out  1  data done pulse
- o_d_err  out  1  data timed out; valid with o_d_ack
- o_d_rdata  out  XLEN  load data; valid with o_d_ack
- o_mem_req  out  1  bus request; held until i_mem_ack
- o_mem_we  out  1  bus write
- o_mem_addr  out  XLEN  bus address
- o_mem_wdata  out  XLEN  bus write data
- o_mem_be  out  4  bus byte enables; 4'hF for fetch
- i_mem_ack  in  1  bus completion
- i_mem_rdata  in  XLEN  bus read data; valid with i_mem_ack

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_D.
- Reset (asynchronous, i_rst_n=0):
  - State = IDLE; streak and timeout counters = 0.
  - All o_mem_* registers = 0.
  - All acks and errs = 0; both rdata outputs = 0.
  - A reset mid-transaction abandons it. No ack is issued, and any later i_mem_ack is ignored.
- IDLE arbitration, evaluated every cycle:
  - Data is granted when i_d_req=1, unless i_if_req=1 and streak==MAX_D_STREAK; in that case fetch is granted.
  - Fetch is granted when only i_if_req=1.
  - Grant is registered. Next cycle: state = BUSY_x, o_mem_req=1, and addr/we/wdata/be are latched from the winner.
  - Fetch grant drives we=0, wdata=0, be=4'hF.
- Streak counter:
  - Increments on a data grant while i_if_req=1, saturating at MAX_D_STREAK.
  - Clears on a fetch grant, and on any IDLE cycle with i_if_req=0.
- BUSY_x:
  - o_mem_* outputs hold stable until completion.
  - On i_mem_ack=1: o_x_ack=1 combinationally in the same cycle and o_x_rdata=i_mem_rdata. Next cycle: o_mem_req=0, state = IDLE.
  - Minimum occupancy per transaction is 1 BUSY cycle plus 1 IDLE cycle.
- Latency: request first seen in IDLE at cycle N gives o_mem_req at N+1. The earliest ack is at N+1 when memory acks in its first cycle.
- Timeout:
  - The counter clears on grant and increments each BUSY cycle with i_mem_ack=0.
  - When TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 with no ack: o_x_ack=1, o_x_err=1, o_x_rdata=0. Next cycle: o_mem_req=0, state = IDLE.
  - An ack arriving in the same cycle as expiry wins, with err=0.
- Non-owner outputs: ack, err and rdata for the non-owning port are always 0.
- Acks in IDLE: i_mem_ack seen while in IDLE is ignored (no stray ack).
- Requester rules:
  - Requester must keep req and its payload stable until its ack.
  - A requester deasserting before its ack is a protocol violation; the arbiter still completes the bus transaction and pulses ack.
  - A requester may re-request in the cycle after its ack and is eligible in the next IDLE arbitration.
- Counter widths: $clog2(MAX_D_STREAK+1) for streak; $clog2(TIMEOUT_CYCLES+1), minimum 1, for timeout.

Decomposition:
- The shared arvi package holds:
  - The state enum typedef (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D).
  - A packed struct mem_req_t {we, addr, wdata, be} used for latching.
  - Constant BE_WORD=4'hF.
- One natural sub-module: arb_timeout_ctr. It takes clear, enable and expiry inputs and outputs o_expired, so it can be reused by later bus masters.
- The rest stays flat.

Test Plan:
- Lone fetch:
  - Stimulus: i_if_req=1, addr=0x0000_0100; memory acks 2 cycles after o_mem_req with rdata=0x0000_0013.
  - Required: o_mem_be=4'hF, o_mem_we=0; o_if_ack pulses 1 cycle with rdata=0x13, err=0; o_d_ack stays 0.
- Simultaneous requests:
  - Stimulus: both req=1 at cycle N; data is a store, addr=0x2000, wdata=0xDEADBEEF, be=4'b0011; memory acks in 1 cycle.
  - Required: data is served first with o_mem_we=1, be=0011. Fetch is granted in the following IDLE.
- Starvation guard:
  - Stimulus: fetch held, data re-requesting continuously, memory always acks in 1 cycle, MAX_D_STREAK=4.
  - Required: exactly 4 data acks, then 1 fetch grant, then the streak restarts at 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, data load to 0x3000, memory never acks.
  - Required: o_d_ack=1, o_d_err=1, o_d_rdata=0 in the 8th BUSY cycle. o_mem_req drops the next cycle, and a late i_mem_ack afterwards produces no ack.
- Ack at expiry:
  - Stimulus: TIMEOUT_CYCLES=8; i_mem_ack arrives exactly in the 8th BUSY cycle with rdata=0x55.
  - Required: ack with err=0, rdata=0x55.
- Reset mid-transaction:
  - Stimulus: i_rst_n=0 asynchronously while in BUSY_D.
  - Required: o_mem_req=0 immediately with no clock edge; all acks 0; state IDLE. After release, a pending i_if_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter and its helpers.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_XLEN = 32;
    localparam logic [3:0]  BE_WORD  = 4'hF;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                we;
        logic [MEM_XLEN-1:0] addr;
        logic [MEM_XLEN-1:0] wdata;
        logic [3:0]          be;
    } mem_req_t;

    // Width of a counter that must hold values 0..max_val, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the final one.
module arb_timeout_ctr #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables expiry entirely.
    assign o_expired = i_enable && (i_limit != '0) && (cnt_q == (i_limit - W'(1)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory bus between the fetch port and the data port,
// with a fetch starvation guard and a per-transaction bus timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN           = MEM_XLEN,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_ack,
    output logic            o_if_err,
    output logic [XLEN-1:0] o_if_rdata,

    input  logic            i_d_req,
    input  logic            i_d_we,
    input  logic [XLEN-1:0] i_d_addr,
    input  logic [XLEN-1:0] i_d_wdata,
    input  logic [3:0]      i_d_be,
    output logic            o_d_ack,
    output logic            o_d_err,
    output logic [XLEN-1:0] o_d_rdata,

    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_be,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam int unsigned SW = cnt_width(MAX_D_STREAK);
    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYCLES);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    mem_req_t      mem_q, mem_d;
    logic          mem_req_q, mem_req_d;

    logic busy;
    logic grant_d;
    logic grant_if;
    logic fetch_starved;
    logic tmo_clear;
    logic tmo_enable;
    logic expired;
    logic done;

    assign busy          = (state_q != ARB_IDLE);
    assign fetch_starved = i_if_req && (streak_q == STREAK_MAX);
    assign grant_d       = !busy && i_d_req && !fetch_starved;
    assign grant_if      = !busy && i_if_req && !grant_d;

    assign tmo_clear  = grant_d || grant_if;
    assign tmo_enable = busy && !i_mem_ack;
    // An ack in the expiry cycle wins because the watchdog is only enabled without one.
    assign done       = busy && (i_mem_ack || expired);

    arb_timeout_ctr #(
        .W (TW)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (tmo_clear),
        .i_enable  (tmo_enable),
        .i_limit   (TMO_LIMIT),
        .o_expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        mem_d     = mem_q;
        mem_req_d = mem_req_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (!i_if_req) begin
                    streak_d = '0;
                end
                if (grant_d) begin
                    state_d   = ARB_BUSY_D;
                    mem_req_d = 1'b1;
                    mem_d     = '{we: i_d_we, addr: i_d_addr, wdata: i_d_wdata, be: i_d_be};
                    if (i_if_req && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (grant_if) begin
                    state_d   = ARB_BUSY_IF;
                    mem_req_d = 1'b1;
                    mem_d     = '{we: 1'b0, addr: i_if_addr, wdata: '0, be: BE_WORD};
                    streak_d  = '0;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_D: begin
                if (done) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ARB_IDLE;
            streak_q  <= '0;
            mem_q     <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            mem_q     <= mem_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_q.we;
    assign o_mem_addr  = mem_q.addr;
    assign o_mem_wdata = mem_q.wdata;
    assign o_mem_be    = mem_q.be;

    // Completion is returned combinationally to the owner only; the other port stays quiet.
    always_comb begin
        o_if_ack   = 1'b0;
        o_if_err   = 1'b0;
        o_if_rdata = '0;
        o_d_ack    = 1'b0;
        o_d_err    = 1'b0;
        o_d_rdata  = '0;
        if (state_q == ARB_BUSY_IF) begin
            o_if_ack   = done;
            o_if_err   = expired;
            o_if_rdata = i_mem_ack ? i_mem_rdata : '0;
        end
        if (state_q == ARB_BUSY_D) begin
            o_d_ack   = done;
            o_d_err   = expired;
            o_d_rdata = i_mem_ack ? i_mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        mem_ack_r = 1'b0;
    logic        late_ack  = 1'b0;
    logic [31:0] rd_val    = 32'h0;
    wire         mem_ack   = mem_ack_r | late_ack;
    wire  [31:0] mem_rdata = rd_val;

    logic        o_if_ack, o_if_err, o_d_ack, o_d_err;
    logic [31:0] o_if_rdata, o_d_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int total = 0;
    int bad   = 0;
    int lat   = 0;

    mem_port_arbiter #(
        .XLEN           (32),
        .MAX_D_STREAK   (MAXS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (o_if_ack),
        .o_if_err    (o_if_err),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .i_d_be      (d_be),
        .o_d_ack     (o_d_ack),
        .o_d_err     (o_d_err),
        .o_d_rdata   (o_d_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Memory: acks in the (lat+1)-th cycle that o_mem_req is seen high.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!o_mem_req) begin
                cnt       = 0;
                mem_ack_r = 1'b0;
            end else begin
                mem_ack_r = (cnt == lat);
                cnt++;
            end
        end
    end

    // Reference model: who owns the bus, how long it has waited, and the data run length.
    int          m_owner = 0;  // 0 none, 1 fetch, 2 data
    int          m_age   = 0;
    int          m_run   = 0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [3:0]  m_be    = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0;
            m_age   <= 0;
            m_run   <= 0;
        end else if (m_owner == 0) begin
            m_age <= 0;
            if (d_req && !(if_req && m_run >= MAXS)) begin
                m_owner <= 2;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
                m_run   <= if_req ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
            end else if (if_req) begin
                m_owner <= 1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= 32'h0;
                m_be    <= 4'hF;
                m_run   <= 0;
            end else begin
                m_run <= 0;
            end
        end else if (mem_ack || m_age == TMO - 1) begin
            m_owner <= 0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        logic xp, fin;
        if (!rst_n) begin
            chk("rst_mem_req", 32'(o_mem_req), 32'h0);
            chk("rst_if_ack", 32'(o_if_ack), 32'h0);
            chk("rst_d_ack", 32'(o_d_ack), 32'h0);
        end else begin
            xp  = (m_owner != 0) && (m_age == TMO - 1) && !mem_ack;
            fin = (m_owner != 0) && (mem_ack || xp);
            chk("mem_req", 32'(o_mem_req), 32'(m_owner != 0));
            if (m_owner != 0) begin
                chk("mem_we", 32'(o_mem_we), 32'(m_we));
                chk("mem_addr", o_mem_addr, m_addr);
                chk("mem_wdata", o_mem_wdata, m_wdata);
                chk("mem_be", 32'(o_mem_be), 32'(m_be));
            end
            chk("if_ack", 32'(o_if_ack), 32'(fin && m_owner == 1));
            chk("if_err", 32'(o_if_err), 32'(xp && m_owner == 1));
            chk("if_rdata", o_if_rdata, (m_owner == 1 && mem_ack) ? mem_rdata : 32'h0);
            chk("d_ack", 32'(o_d_ack), 32'(fin && m_owner == 2));
            chk("d_err", 32'(o_d_err), 32'(xp && m_owner == 2));
            chk("d_rdata", o_d_rdata, (m_owner == 2 && mem_ack) ? mem_rdata : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of negedges until the chosen ack, or -1 if it never came.
    task automatic wait_ack(input bit is_d, input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (is_d ? o_d_ack : o_if_ack) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int dcnt;
        int runs[$];

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_be    = 4'h0;

        repeat (2) @(negedge clk);
        chk("reset_mem_req", 32'(o_mem_req), 32'h0);
        chk("reset_mem_addr", o_mem_addr, 32'h0);
        chk("reset_mem_be", 32'(o_mem_be), 32'h0);
        chk("reset_if_rdata", o_if_rdata, 32'h0);
        chk("reset_d_rdata", o_d_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Lone fetch, memory answers in the third bus cycle.
        lat     = 2;
        rd_val  = 32'h0000_0013;
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        wait_ack(1'b0, 20, cyc);
        chk("fetch_latency", 32'(cyc), 32'd4);
        chk("fetch_rdata", o_if_rdata, 32'h13);
        chk("fetch_err", 32'(o_if_err), 32'h0);
        chk("fetch_be", 32'(o_mem_be), 32'hF);
        chk("fetch_we", 32'(o_mem_we), 32'h0);
        chk("fetch_no_d_ack", 32'(o_d_ack), 32'h0);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_ack_pulse", 32'(o_if_ack), 32'h0);
        tick();

        // Simultaneous: data store wins, fetch follows in the next idle.
        lat     = 0;
        rd_val  = 32'h1111_2222;
        if_addr = 32'h0000_0104;
        d_we    = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'b0011;
        if_req  = 1'b1;
        d_req   = 1'b1;
        wait_ack(1'b1, 20, cyc);
        chk("simul_d_latency", 32'(cyc), 32'd2);
        chk("simul_d_we", 32'(o_mem_we), 32'h1);
        chk("simul_d_be", 32'(o_mem_be), 32'h3);
        chk("simul_d_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk("simul_no_if_ack", 32'(o_if_ack), 32'h0);
        tick();
        d_req = 1'b0;
        wait_ack(1'b0, 20, cyc);
        chk("simul_if_latency", 32'(cyc), 32'd2);
        chk("simul_if_addr", o_mem_addr, 32'h0000_0104);
        tick();
        if_req = 1'b0;
        tick();

        // Starvation guard: fetch held, data always requesting.
        lat     = 0;
        d_we    = 1'b0;
        d_addr  = 32'h0000_4000;
        d_wdata = 32'h0;
        d_be    = 4'hF;
        if_addr = 32'h0000_0200;
        if_req  = 1'b1;
        d_req   = 1'b1;
        dcnt    = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_d_ack) dcnt++;
            if (o_if_ack) begin
                runs.push_back(dcnt);
                dcnt = 0;
                if (runs.size() == 2) break;
            end
        end
        chk("starve_fetches", 32'(runs.size()), 32'd2);
        chk("starve_run0", 32'(runs[0]), 32'd4);
        chk("starve_run1", 32'(runs[1]), 32'd4);
        tick();
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // Timeout: memory never answers a data load.
        lat    = 1000;
        rd_val = 32'h0000_00AA;
        d_we   = 1'b0;
        d_addr = 32'h0000_3000;
        d_req  = 1'b1;
        wait_ack(1'b1, 20, cyc);
        chk("tmo_latency", 32'(cyc), 32'd9);
        chk("tmo_err", 32'(o_d_err), 32'h1);
        chk("tmo_rdata", o_d_rdata, 32'h0);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("tmo_req_drop", 32'(o_mem_req), 32'h0);
        tick();
        late_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_d", 32'(o_d_ack), 32'h0);
        chk("late_ack_if", 32'(o_if_ack), 32'h0);
        tick();
        late_ack = 1'b0;
        tick();

        // Ack in the expiry cycle; the requester also drops req early, which must not matter.
        lat    = 7;
        rd_val = 32'h0000_0055;
        d_addr = 32'h0000_3004;
        d_req  = 1'b1;
        repeat (3) @(negedge clk);
        tick();
        d_req = 1'b0;
        wait_ack(1'b1, 20, cyc);
        chk("expiry_latency", 32'(cyc), 32'd6);
        chk("expiry_err", 32'(o_d_err), 32'h0);
        chk("expiry_rdata", o_d_rdata, 32'h55);
        tick();
        tick();

        // Asynchronous reset while data owns the bus; pending fetch served afterwards.
        lat     = 1000;
        d_addr  = 32'h0000_5000;
        if_addr = 32'h0000_6000;
        d_req   = 1'b1;
        if_req  = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk("arst_mem_req", 32'(o_mem_req), 32'h0);
        chk("arst_d_ack", 32'(o_d_ack), 32'h0);
        chk("arst_if_ack", 32'(o_if_ack), 32'h0);
        lat    = 1;
        rd_val = 32'h0000_0077;
        tick();
        tick();
        rst_n = 1'b1;
        wait_ack(1'b0, 20, cyc);
        chk("post_rst_latency", 32'(cyc), 32'd3);
        chk("post_rst_rdata", o_if_rdata, 32'h77);
        chk("post_rst_err", 32'(o_if_err), 32'h0);
        chk("post_rst_addr", o_mem_addr, 32'h0000_6000);
        tick();
        if_req = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
